branch_unit: RTL and testbench
==============================

// Module: branch_unit
// PURPOSE
//  Branch/jump resolution for the CPU execute stage. Decides from the branch mode and ALU
//  result flags whether the PC is redirected, and computes the target address.
//  Covers PC-relative branches, J (pseudo-direct) and JR (register); purely combinational.
// PARAMETERS
//  none (widths fixed: 32-bit addresses, 16-bit offset, 26-bit jump index)
// PORTS
//  clk                  in   1   system clock; present for interface uniformity, no state uses it
//  rst                  in   1   asynchronous, active-low reset; outputs are independent of it
//  mode                 in   4   branch mode (BranchModesPackage enum)
//  pcAddress            in   32  PC value branches are relative to (already-incremented PC)
//  branchAddressOffset  in   16  signed word offset (instruction immediate)
//  jumpAddress          in   26  J-type word index
//  jumpRegisterAddress  in   32  rs value for JR
//  resultZero           in   1   ALU result == 0
//  resultNegative       in   1   ALU result < 0
//  resultPositive       in   1   ALU result > 0
//  shouldUseNewPC       out  1   1 = redirect PC to branchTo this cycle
//  branchTo             out  32  target address; 'x (don't-care) when shouldUseNewPC=0
// BEHAVIOUR
//  - Fully combinational; outputs settle within the same cycle; zero latency.
//  - Reset has no effect on outputs; correct results are required while rst=0 (asserted).
//  - Taken condition by mode:
//    NONE: never; BEQ: zero; BNE: !zero; BGEZ: zero|positive; BGTZ: positive;
//    BLEZ: zero|negative; BLTZ: negative; J, JR: always;
//    BC1T/BC1F: see CONFIGURATION; undefined mode codes: never.
//  - Branch target = pcAddress + ({{14{off[15]}}, off, 2'b00}), mod 2^32 (wraps silently).
//  - J target = {pcAddress[31:28], jumpAddress, 2'b00}.
//  - JR target = jumpRegisterAddress unmodified (no alignment check).
//  - Not taken: shouldUseNewPC=0 and branchTo='x on all 32 bits (the bench checks with ===).
//  - Inconsistent flag combinations (e.g. several set) are evaluated literally per the table.
//  - NONE ignores all flags, including all-zero and all-set.
// CONFIGURATION
//  - Macro BRANCH_BC1_EN (default undefined).
//  - Defined: adds input fpuCondition (1 bit, after resultPositive).
//    BC1T is taken when fpuCondition=1, BC1F when fpuCondition=0.
//    Both use the PC-relative branch target.
//  - Undefined: no extra port; BC1T/BC1F are never taken (branchTo='x).
// STRUCTURE
//  - BranchModesPackage: typedef enum logic[3:0] BranchMode_t, with constants
//    BranchMode_NONE=0, _BEQ=1, _BGEZ=2, _BGTZ=3, _BLEZ=4, _BLTZ=5, _BNE=6,
//    _BC1T=7, _BC1F=8, _J=9, _JR=10.
//  - One sub-module, branch_target_calc: produces the relative, J and JR targets.
//    The top level holds the condition decode and the output mux (always_comb, unique case).
// TESTING (pc=AABBCCDD, off=FFFF, jump=AABBCC, jr=AABBCCDD, rst held 0 throughout)
//  - NONE with each flag combination 0..7 -> shouldUseNewPC=0, branchTo==='x.
//  - BEQ with zero=1 -> taken, branchTo=AABBCCD9; BEQ with pos=1 -> not taken, 'x.
//  - BGEZ: zero or pos -> AABBCCD9; neg -> not taken.
//    BGTZ: only pos taken.
//    BLTZ: only neg taken.
//    BNE: pos or neg taken, zero not taken.
//  - BLEZ with neg=1 and off=0FFF -> taken, branchTo=AABC0CD9; BLEZ with pos=1 -> not taken.
//  - J -> taken, branchTo=A2AAEF30.
//    JR with pc=11223344, jr=ABCDABCD -> taken, branchTo=ABCDABCD.
//  - With BRANCH_BC1_EN: BC1T fpuCondition=1 -> AABBCCD9; BC1F fpuCondition=1 -> not taken.

Source files
------------

// File: rtl/branch_unit_pkg.sv
// branch_unit_pkg: branch mode encoding shared by the branch unit, its interface and bench.
// Contents: BranchMode_t enum (4-bit), codes 11..15 are undefined and never taken.
package BranchModesPackage;
   typedef enum logic [3:0] {
      BranchMode_NONE = 4'd0,
      BranchMode_BEQ  = 4'd1,
      BranchMode_BGEZ = 4'd2,
      BranchMode_BGTZ = 4'd3,
      BranchMode_BLEZ = 4'd4,
      BranchMode_BLTZ = 4'd5,
      BranchMode_BNE  = 4'd6,
      BranchMode_BC1T = 4'd7,
      BranchMode_BC1F = 4'd8,
      BranchMode_J    = 4'd9,
      BranchMode_JR   = 4'd10
   } BranchMode_t;
endpackage

// File: rtl/branch_unit_if.sv
// branch_unit_if: execute-stage branch request/response bundle.
// Signals: mode, pcAddress, branchAddressOffset, jumpAddress, jumpRegisterAddress,
//   resultZero/Negative/Positive (+ fpuCondition when BRANCH_BC1_EN) -> shouldUseNewPC, branchTo.
// Modports: master drives the request, slave (branch_unit) drives the response.
interface branch_unit_if;
   import BranchModesPackage::*;
   BranchMode_t mode;
   logic [31:0] pcAddress;
   logic [15:0] branchAddressOffset;
   logic [25:0] jumpAddress;
   logic [31:0] jumpRegisterAddress;
   logic        resultZero;
   logic        resultNegative;
   logic        resultPositive;
`ifdef BRANCH_BC1_EN
   logic        fpuCondition;
`endif
   logic        shouldUseNewPC;
   logic [31:0] branchTo;
   modport master (
      input  shouldUseNewPC, branchTo,
      output mode, pcAddress, branchAddressOffset, jumpAddress, jumpRegisterAddress,
             resultZero, resultNegative, resultPositive
`ifdef BRANCH_BC1_EN
      , fpuCondition
`endif
   );
   modport slave (
      output shouldUseNewPC, branchTo,
      input  mode, pcAddress, branchAddressOffset, jumpAddress, jumpRegisterAddress,
             resultZero, resultNegative, resultPositive
`ifdef BRANCH_BC1_EN
      , fpuCondition
`endif
   );
endinterface

// File: rtl/branch_unit_target_calc.sv
// branch_target_calc: candidate targets for PC-relative, J and JR redirects.
// Ports: i_pc, i_off (signed word offset), i_jump (word index), i_jr -> o_rel, o_j, o_jr.
module branch_target_calc (
   input  logic [31:0] i_pc,
   input  logic [15:0] i_off,
   input  logic [25:0] i_jump,
   input  logic [31:0] i_jr,
   output logic [31:0] o_rel,
   output logic [31:0] o_j,
   output logic [31:0] o_jr
);
   // Sign-extended byte offset; the add wraps modulo 2^32.
   assign o_rel = i_pc + {{14{i_off[15]}}, i_off, 2'b00};
   assign o_j   = {i_pc[31:28], i_jump, 2'b00};
   assign o_jr  = i_jr;
endmodule

// File: rtl/branch_unit.sv
// branch_unit: combinational branch/jump resolution for the execute stage.
// Ports: clk, rst (active-low, unused: no state), bus (branch_unit_if.slave).
// Option: BRANCH_BC1_EN enables BC1T/BC1F on fpuCondition; otherwise they are never taken.
module branch_unit
   import BranchModesPackage::*;
(
   input  logic clk,
   input  logic rst,
   branch_unit_if.slave bus
);
   logic [31:0] w_rel;
   logic [31:0] w_j;
   logic [31:0] w_jr;
   logic [31:0] w_target;
   logic        w_taken;
   logic        w_unused;
   assign w_unused = &{1'b0, clk, rst};
   branch_target_calc u_calc (
      .i_pc   (bus.pcAddress),
      .i_off  (bus.branchAddressOffset),
      .i_jump (bus.jumpAddress),
      .i_jr   (bus.jumpRegisterAddress),
      .o_rel  (w_rel),
      .o_j    (w_j),
      .o_jr   (w_jr)
   );
   // Flags are taken literally, so inconsistent combinations follow the table as written.
   always_comb begin
      w_taken  = 1'b0;
      w_target = w_rel;
      unique case (bus.mode)
         BranchMode_BEQ:  w_taken = bus.resultZero;
         BranchMode_BNE:  w_taken = !bus.resultZero;
         BranchMode_BGEZ: w_taken = bus.resultZero | bus.resultPositive;
         BranchMode_BGTZ: w_taken = bus.resultPositive;
         BranchMode_BLEZ: w_taken = bus.resultZero | bus.resultNegative;
         BranchMode_BLTZ: w_taken = bus.resultNegative;
`ifdef BRANCH_BC1_EN
         BranchMode_BC1T: w_taken = bus.fpuCondition;
         BranchMode_BC1F: w_taken = !bus.fpuCondition;
`endif
         BranchMode_J: begin
            w_taken  = 1'b1;
            w_target = w_j;
         end
         BranchMode_JR: begin
            w_taken  = 1'b1;
            w_target = w_jr;
         end
         default: w_taken = 1'b0;
      endcase
   end
   assign bus.shouldUseNewPC = w_taken;
   assign bus.branchTo       = w_taken ? w_target : 'x;
endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: directed-vector bench for branch_unit with hand-computed targets.
module tb_branch_unit;
   import BranchModesPackage::*;
   localparam logic [31:0] X32 = 'x;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vec = 0;
   int   err = 0;
   branch_unit_if bus ();
   branch_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   // f = {zero, negative, positive}
   task automatic apply(input BranchMode_t m, input logic [2:0] f);
      @(negedge clk);
      bus.mode           = m;
      bus.resultZero     = f[2];
      bus.resultNegative = f[1];
      bus.resultPositive = f[0];
   endtask
   task automatic chk(input string tag, input logic exp_t, input logic [31:0] exp_b);
      #1;
      vec++;
      assert (bus.shouldUseNewPC === exp_t && bus.branchTo === exp_b)
      else begin
         err++;
         $error("FAIL %s: got taken=%b branchTo=%h, want taken=%b branchTo=%h",
                tag, bus.shouldUseNewPC, bus.branchTo, exp_t, exp_b);
      end
   endtask
   initial begin
      bus.mode                = BranchMode_NONE;
      bus.pcAddress           = 32'hAABBCCDD;
      bus.branchAddressOffset = 16'hFFFF;
      bus.jumpAddress         = 26'hAABBCC;
      bus.jumpRegisterAddress = 32'hAABBCCDD;
      bus.resultZero          = 1'b0;
      bus.resultNegative      = 1'b0;
      bus.resultPositive      = 1'b0;
`ifdef BRANCH_BC1_EN
      bus.fpuCondition        = 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
         apply(BranchMode_NONE, 3'(i));
         chk($sformatf("none_f%0d", i), 1'b0, X32);
      end
      apply(BranchMode_BEQ, 3'b100);  chk("beq_zero", 1'b1, 32'hAABBCCD9);
      apply(BranchMode_BEQ, 3'b001);  chk("beq_pos", 1'b0, X32);
      apply(BranchMode_BEQ, 3'b111);  chk("beq_all", 1'b1, 32'hAABBCCD9);
      apply(BranchMode_BGEZ, 3'b100); chk("bgez_zero", 1'b1, 32'hAABBCCD9);
      apply(BranchMode_BGEZ, 3'b001); chk("bgez_pos", 1'b1, 32'hAABBCCD9);
      apply(BranchMode_BGEZ, 3'b010); chk("bgez_neg", 1'b0, X32);
      apply(BranchMode_BGTZ, 3'b001); chk("bgtz_pos", 1'b1, 32'hAABBCCD9);
      apply(BranchMode_BGTZ, 3'b100); chk("bgtz_zero", 1'b0, X32);
      apply(BranchMode_BGTZ, 3'b010); chk("bgtz_neg", 1'b0, X32);
      apply(BranchMode_BLTZ, 3'b010); chk("bltz_neg", 1'b1, 32'hAABBCCD9);
      apply(BranchMode_BLTZ, 3'b100); chk("bltz_zero", 1'b0, X32);
      apply(BranchMode_BLTZ, 3'b001); chk("bltz_pos", 1'b0, X32);
      apply(BranchMode_BNE, 3'b001);  chk("bne_pos", 1'b1, 32'hAABBCCD9);
      apply(BranchMode_BNE, 3'b010);  chk("bne_neg", 1'b1, 32'hAABBCCD9);
      apply(BranchMode_BNE, 3'b100);  chk("bne_zero", 1'b0, X32);
      bus.branchAddressOffset = 16'h0FFF;
      apply(BranchMode_BLEZ, 3'b010); chk("blez_neg", 1'b1, 32'hAABC0CD9);
      apply(BranchMode_BLEZ, 3'b100); chk("blez_zero", 1'b1, 32'hAABC0CD9);
      apply(BranchMode_BLEZ, 3'b001); chk("blez_pos", 1'b0, X32);
      bus.branchAddressOffset = 16'hFFFF;
      apply(BranchMode_J, 3'b000);    chk("j", 1'b1, 32'hA2AAEF30);
      apply(BranchMode_BC1T, 3'b111); chk("bc1t_flags", 1'b0, X32);
      apply(BranchMode_BC1F, 3'b111); chk("bc1f_flags", 1'b0, X32);
      apply(BranchMode_t'(4'd11), 3'b111); chk("undef_11", 1'b0, X32);
      apply(BranchMode_t'(4'd15), 3'b111); chk("undef_15", 1'b0, X32);
      bus.pcAddress           = 32'h11223344;
      bus.jumpRegisterAddress = 32'hABCDABCD;
      apply(BranchMode_JR, 3'b000);   chk("jr", 1'b1, 32'hABCDABCD);
      apply(BranchMode_J, 3'b000);    chk("j_pc1", 1'b1, 32'h12AAEF30);
      bus.pcAddress           = 32'hFFFFFFFC;
      bus.branchAddressOffset = 16'h0001;
      apply(BranchMode_BEQ, 3'b100);  chk("wrap_up", 1'b1, 32'h00000000);
      bus.pcAddress           = 32'h00000000;
      bus.branchAddressOffset = 16'hFFFF;
      apply(BranchMode_BEQ, 3'b100);  chk("wrap_down", 1'b1, 32'hFFFFFFFC);
`ifdef BRANCH_BC1_EN
      bus.pcAddress    = 32'hAABBCCDD;
      bus.fpuCondition = 1'b1;
      apply(BranchMode_BC1T, 3'b000); chk("bc1t_fpu1", 1'b1, 32'hAABBCCD9);
      apply(BranchMode_BC1F, 3'b000); chk("bc1f_fpu1", 1'b0, X32);
      bus.fpuCondition = 1'b0;
      apply(BranchMode_BC1T, 3'b000); chk("bc1t_fpu0", 1'b0, X32);
      apply(BranchMode_BC1F, 3'b000); chk("bc1f_fpu0", 1'b1, 32'hAABBCCD9);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end
endmodule
